// File: rtl/spi_poll_sched.sv
`timescale 1ns/1ps
// spi_poll_sched
// ---------------------------------------------------------------------------
// SPI master-side frame scheduler for the peripheral-to-controller (CIPO)
// input path. A frame of DATA_WIDTH*FRAME_BYTES bits is clocked in MSB first.
// The result is presented on frame_out, and frame_valid_out pulses for one
// cycle when frame_out is loaded.
//
// Frame sequence:
//   IDLE -> SETUP (CS_SETUP cycles, cs_n low, dclk low)
//        -> XFER  (N bit periods, DCLK_HALF low + DCLK_HALF high)
//        -> HOLD  (CS_SETUP cycles, cs_n low, dclk low)
//        -> DONE  (one cycle, frame_out loaded, frame_valid_out high)
//
// Request semantics:
//   start_in is a request level that is sampled only while the FSM is in IDLE.
//   There is no ready signal. busy_out high means a request is dropped, and the
//   request is not queued.
//
// Optional build macro SPI_POLL_AUTO_EN:
//   When this macro is defined, a free-running poll counter with period
//   POLL_PERIOD sets a one-deep pending flag on each wrap. A pending flag
//   starts a frame in the same way as start_in.
//
// Ports:
//   clk_in          system clock
//   rst_n_in        asynchronous active-low reset
//   start_in        frame request (sampled in IDLE only)
//   busy_out        high whenever the FSM is not in IDLE
//   frame_out       last completed frame; byte 0 occupies the MSBs
//   frame_valid_out one-cycle pulse when frame_out updates
//   cs_n_out        chip select, active low, registered
//   dclk_out        data clock, idles low, registered
//   cipo_in         asynchronous serial data from the device
// ---------------------------------------------------------------------------
module spi_poll_sched #(
  parameter int DATA_WIDTH  = 8,
  parameter int FRAME_BYTES = 2,
  parameter int DCLK_HALF   = 50,
  parameter int CS_SETUP    = 100,
  parameter int POLL_PERIOD = 1666666
) (
  input  logic                                clk_in,
  input  logic                                rst_n_in,
  input  logic                                start_in,
  output logic                                busy_out,
  output logic [DATA_WIDTH*FRAME_BYTES-1:0]   frame_out,
  output logic                                frame_valid_out,
  output logic                                cs_n_out,
  output logic                                dclk_out,
  input  logic                                cipo_in
);

  localparam int N       = DATA_WIDTH * FRAME_BYTES;
  localparam int BCW     = $clog2(N + 1);
  localparam int CNT_MAX = (CS_SETUP > DCLK_HALF) ? CS_SETUP : DCLK_HALF;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]  SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0]  HALF_LAST  = CW'(DCLK_HALF - 1);
  localparam logic [BCW-1:0] BIT_LAST   = BCW'(N - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;      // cycles within SETUP/HOLD or a DCLK half
  logic             phase_q, phase_d;  // 0 = low half, 1 = high half
  logic [BCW-1:0]   bit_q, bit_d;
  logic [N-1:0]     shift_q, shift_d;
  logic [N-1:0]     frame_q, frame_d;
  logic             valid_q, valid_d;
  logic             cs_n_q, cs_n_d;
  logic             dclk_q, dclk_d;
  logic             sync1_q, sync2_q;
  logic             trigger;

`ifdef SPI_POLL_AUTO_EN
  localparam int            PW        = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);

  logic [PW-1:0] poll_q, poll_d;
  logic          pend_q, pend_d;
  logic          poll_wrap;

  // A pending request is always consumed when the FSM is in IDLE. A pending
  // request is therefore cleared in IDLE unless a new wrap sets it again in
  // the same cycle. Wraps that occur while the FSM is busy collapse into one
  // pending request.
  always_comb begin
    poll_wrap = (poll_q == POLL_LAST);
    poll_d    = poll_wrap ? '0 : poll_q + PW'(1);
    pend_d    = poll_wrap | (pend_q & (state_q != ST_IDLE));
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      poll_q <= '0;
      pend_q <= 1'b0;
    end else begin
      poll_q <= poll_d;
      pend_q <= pend_d;
    end
  end

  assign trigger = start_in | pend_q;
`else
  assign trigger = start_in;
`endif

  // cipo_in is asynchronous to clk_in, so it is resynchronised before use.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= cipo_in;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      bit_q   <= '0;
      shift_q <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      cs_n_q  <= 1'b1;
      dclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      cs_n_q  <= cs_n_d;
      dclk_q  <= dclk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    frame_d = frame_q;
    valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        phase_d = 1'b0;
        bit_d   = '0;
        if (trigger) begin
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = ST_XFER;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_XFER: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            // The last cycle of the high half is the sample point. The
            // device changed the data on the previous falling edge, so the
            // data has been stable for a full half period.
            phase_d = 1'b0;
            shift_d = (shift_q << 1) | N'(sync2_q);
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = ST_HOLD;
            end else begin
              bit_d = bit_q + BCW'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_HOLD: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
          // frame_out and its strobe are registered on entry to DONE, so
          // both are visible during the DONE cycle.
          frame_d = shift_q;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The pin values are computed from the next state. This keeps cs_n and
    // dclk aligned with state_q while both pins are driven straight from
    // flops.
    cs_n_d = !((state_d == ST_SETUP) || (state_d == ST_XFER) || (state_d == ST_HOLD));
    dclk_d = (state_d == ST_XFER) && phase_d;
  end

  assign busy_out        = (state_q != ST_IDLE);
  assign frame_out       = frame_q;
  assign frame_valid_out = valid_q;
  assign cs_n_out        = cs_n_q;
  assign dclk_out        = dclk_q;

endmodule
